// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store initiator: access sizes, FSM states
// and the size-to-byte-count decode.
package lsu_pkg;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      ACC0,
      WAIT0,
      ACC1,
      WAIT1,
      RESP
   } lsu_state_t;

   // Reserved size decodes to zero bytes; callers flag it as an error.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_WORD: size_bytes = 3'd4;
         SIZE_HALF: size_bytes = 3'd2;
         SIZE_BYTE: size_bytes = 3'd1;
         default:   size_bytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store data/strobe placement across two words
// and load byte extraction with zero/sign extension.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] wdata,
   input  logic [31:0] word0,
   input  logic [31:0] word1,
   output logic [31:0] st_lo,
   output logic [31:0] st_hi,
   output logic [3:0]  strb_lo,
   output logic [3:0]  strb_hi,
   output logic [31:0] ld_data
);

   logic [7:0]  lane_mask;
   logic [7:0]  strb_all;
   logic [63:0] st_all;
   logic [31:0] ld_shift;

   always_comb begin
      case (size_bytes(size))
         3'd4:    lane_mask = 8'h0F;
         3'd2:    lane_mask = 8'h03;
         3'd1:    lane_mask = 8'h01;
         default: lane_mask = 8'h00;
      endcase
      strb_all = lane_mask << offset;
      st_all   = {32'b0, wdata} << {offset, 3'b000};
      ld_shift = 32'({word1, word0} >> {offset, 3'b000});

      st_lo   = st_all[31:0];
      st_hi   = st_all[63:32];
      strb_lo = strb_all[3:0];
      strb_hi = strb_all[7:4];

      case (size)
         SIZE_BYTE: ld_data = sign ? {{24{ld_shift[7]}}, ld_shift[7:0]}
                                   : {24'b0, ld_shift[7:0]};
         SIZE_HALF: ld_data = sign ? {{16{ld_shift[15]}}, ld_shift[15:0]}
                                   : {16'b0, ld_shift[15:0]};
         default:   ld_data = ld_shift;
      endcase
   end

endmodule

// File: rtl/lsu_initiator.sv
// Load/store initiator: accepts one core access at a time and issues one or
// two word-aligned memory transactions, then returns a single response.
module lsu_initiator
   import lsu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [1:0]       req_size,
   input  logic             req_sign,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   output logic             resp_err,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             mem_valid,
   input  logic             mem_ready,
   output logic             mem_write,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [3:0]       mem_wstrb,
   input  logic             mem_rvalid,
   input  logic [WIDTH-1:0] mem_rdata
);

   lsu_state_t       state, state_next;
   logic             lat_write, lat_sign, lat_err;
   logic [1:0]       lat_size;
   logic [WIDTH-1:0] lat_addr, lat_wdata, word0, word1;

   logic             cur_write, cur_sign, split, dec_err;
   logic [1:0]       cur_size;
   logic [WIDTH-1:0] cur_addr, cur_wdata, word_addr;
   logic [WIDTH-1:0] st_lo, st_hi, ld_data;
   logic [3:0]       strb_lo, strb_hi;

   // In IDLE the live request drives decode so memory outputs can be
   // registered on the accepting edge; afterwards the latched copy does.
   always_comb begin
      cur_write = (state == IDLE) ? req_write : lat_write;
      cur_size  = (state == IDLE) ? req_size  : lat_size;
      cur_sign  = (state == IDLE) ? req_sign  : lat_sign;
      cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
      cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
      word_addr = {cur_addr[WIDTH-1:2], 2'b00};
      split     = ({2'b00, cur_addr[1:0]} + {1'b0, size_bytes(cur_size)}) > 4'd4;
      dec_err   = (cur_size == 2'b11) || (split && !SPLIT_EN);
   end

   lsu_lane_align u_align (
      .offset  (cur_addr[1:0]),
      .size    (cur_size),
      .sign    (cur_sign),
      .wdata   (cur_wdata),
      .word0   (word0),
      .word1   (word1),
      .st_lo   (st_lo),
      .st_hi   (st_hi),
      .strb_lo (strb_lo),
      .strb_hi (strb_hi),
      .ld_data (ld_data)
   );

   always_comb begin
      state_next = state;
      req_ready  = (state == IDLE) && !rst;
      case (state)
         IDLE:  if (req_valid) state_next = dec_err ? RESP : ACC0;
         ACC0:  if (mem_ready) state_next = !cur_write ? WAIT0 : (split ? ACC1 : RESP);
         WAIT0: if (mem_rvalid) state_next = split ? ACC1 : RESP;
         ACC1:  if (mem_ready) state_next = cur_write ? RESP : WAIT1;
         WAIT1: if (mem_rvalid) state_next = RESP;
         RESP:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lat_write <= 1'b0;
         lat_sign  <= 1'b0;
         lat_err   <= 1'b0;
         lat_size  <= 2'b00;
         lat_addr  <= '0;
         lat_wdata <= '0;
         word0     <= '0;
         word1     <= '0;
         mem_valid <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= 4'b0000;
      end else begin
         state <= state_next;
         if (state == IDLE && req_valid) begin
            lat_write <= req_write;
            lat_sign  <= req_sign;
            lat_size  <= req_size;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_err   <= dec_err;
            word1     <= '0;
         end
         if (state == WAIT0 && mem_rvalid) word0 <= mem_rdata;
         if (state == WAIT1 && mem_rvalid) word1 <= mem_rdata;

         mem_valid <= (state_next == ACC0) || (state_next == ACC1);
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= 4'b0000;
         if (state_next == ACC0) begin
            mem_write <= cur_write;
            mem_addr  <= word_addr;
            mem_wdata <= cur_write ? st_lo : '0;
            mem_wstrb <= cur_write ? strb_lo : 4'b0000;
         end else if (state_next == ACC1) begin
            mem_write <= cur_write;
            mem_addr  <= word_addr + 32'd4;
            mem_wdata <= cur_write ? st_hi : '0;
            mem_wstrb <= cur_write ? strb_hi : 4'b0000;
         end
      end
   end

   assign resp_valid = (state == RESP);
   assign resp_err   = (state == RESP) && lat_err;
   assign resp_rdata = (state == RESP && !lat_err && !lat_write) ? ld_data : '0;

endmodule
